prog_clk_divider: RTL and testbench
===================================

# prog_clk_divider

Multi-channel, runtime-programmable clock divider and period-tick generator; successor to the fixed-ratio single-channel divider. Each channel divides i_clk by an integer ratio loaded through a valid/ready config port. New ratios take effect only at a period boundary, so no runt pulses appear. Outputs drive display scan, debounce sampling and slow-logic enables across the design.

## Interface
- CH, 4, number of independent divider channels (≥2)
- CW, 16, counter/ratio width in bits
- CHW, $clog2(CH), channel-select width (derived)
- i_clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- i_en  input  CH  per-channel run enable
- i_cfg_valid  input  1  config request valid
- o_cfg_ready  output  1  config port ready
- i_cfg_ch  input  CHW  target channel
- i_cfg_div  input  CW  divide ratio R
- i_cfg_high  input  CW  high time H in i_clk cycles (used only with DUTY_CFG_EN)
- o_clk  output  CH  divided clocks, registered
- o_tick  output  CH  one-cycle pulse per period, registered
- o_pend  output  CH  channel holds an accepted, not-yet-applied config

## Operation
- Per channel: active R, H; shadow R_s, H_s; counter cnt in 0..R-1; pend flag.
- Reset values: R=2, H=1, cnt=0, pend=0, o_clk=0, o_tick=0, o_pend=0.
- Enabled channel: cnt increments each cycle; at cnt==R-1 it wraps to 0. Period is exactly R cycles.
- Waveform: low first, then high; o_clk=1 iff cnt ≥ R-H. o_tick=1 iff cnt==R-1.
- i_en low: cnt forced to 0, o_clk=0, o_tick=0. Counting resumes from cnt=0 in the first cycle after i_en rises.
- Config handshake: o_cfg_ready = !pend[i_cfg_ch] (combinational on the select). A transfer occurs when valid && ready. It loads R_s/H_s and sets pend.
- Apply: a pending shadow is copied to R/H on the wrap cycle (cnt==R-1 → 0). If the channel is disabled, the copy happens on the next cycle. pend clears in the same cycle.
- Apply and a new transfer to the same channel in one cycle: not possible, because ready is low while pend is set.
- Clamping at accept: R_s = max(i_cfg_div, 2). H_s is clamped to the range 1..R_s-1.
- i_cfg_ch ≥ CH: the transfer completes (ready=1) and the data is discarded.
- Reset mid-operation: all state returns to the reset values immediately; pending configs are lost.

## Timing
- Outputs are registered: o_clk and o_tick in cycle t reflect cnt in cycle t. They are computed from next-state in cycle t-1.
- Config latency: a transfer in cycle t sets o_pend in t+1. New R/H govern the period starting after the current period's wrap. For a disabled channel, they govern from t+2.
- Channels are fully independent; simultaneous wraps or applies on several channels are legal.
- R=2, H=1 gives o_clk = i_clk/2 at 50% duty and o_tick on every second cycle.

## Configuration
- DUTY_CFG_EN defined: H comes from i_cfg_high, clamped as above.
- DUTY_CFG_EN undefined: i_cfg_high is ignored and H = floor(R/2). Low time is R - floor(R/2); for odd R, low is one cycle longer than high.
- The port list is identical in both builds.

## Structure
- Shared package clk_div_pkg holds the reset constants RST_DIV=2 and RST_HIGH=1, plus the clamp helper function for R/H.
- One sub-module, clk_div_chan, holds one channel's counter, shadow registers, pend flag and output registers. It is instantiated CH times in a generate loop.
- The top level holds only channel decode and the ready mux.

## Test plan
- Reset release, all i_en=1, no config → every o_clk toggles every cycle (R=2), o_tick every second cycle, o_pend=0.
- Write ch1 R=5 (default build) → low 3 / high 2 cycles, o_tick on cnt==4. o_pend[1] is high until the first wrap, then clears.
- Write ch0 R=10 mid-period, then attempt a second write to ch0 → o_cfg_ready=0 until the apply. The current period finishes at the old R with no runt pulse.
- R=0 and R=1 writes → clamped to R=2. With DUTY_CFG_EN, R=8, H=9 → H=7 (low 1 / high 7).
- Drop i_en[2] mid-period, hold 5 cycles, raise it → o_clk[2]=0 while low. A restart from cnt=0 gives the first o_tick R cycles after the rise.
- Assert rst_n low with pend set on ch3 → outputs return to 0 asynchronously. After release, ch3 runs at R=2 and the pending config is lost.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: reset constants and ratio/high-time clamp helpers shared by prog_clk_divider
package clk_div_pkg;
  localparam int RST_DIV = 2;
  localparam int RST_HIGH = 1;
  function automatic int unsigned clamp_div(int unsigned div);
    return div < 2 ? 2 : div;
  endfunction
  function automatic int unsigned clamp_high(int unsigned high, int unsigned div);
    return high < 1 ? 1 : high >= div ? div - 1 : high;
  endfunction
endpackage

// File: rtl/prog_clk_divider_if.sv
// prog_clk_divider_if: valid/ready config port of prog_clk_divider
interface prog_clk_divider_if #(parameter int CH = 4, parameter int CW = 16);
  localparam int CHW = $clog2(CH);
  logic i_cfg_valid;
  logic o_cfg_ready;
  logic [CHW-1:0] i_cfg_ch;
  logic [CW-1:0] i_cfg_div;
  logic [CW-1:0] i_cfg_high;
  modport master(output i_cfg_valid, i_cfg_ch, i_cfg_div, i_cfg_high, input o_cfg_ready);
  modport slave(input i_cfg_valid, i_cfg_ch, i_cfg_div, i_cfg_high, output o_cfg_ready);
endinterface

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with shadowed ratio; DUTY_CFG_EN takes high time from the config port
module clk_div_chan
  import clk_div_pkg::*;
#(parameter int CW = 16) (
  input  logic          i_clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [CW-1:0] i_div,
  input  logic [CW-1:0] i_high,
  output logic          o_clk,
  output logic          o_tick,
  output logic          o_pend
);
  logic [CW-1:0] r, h, r_s, h_s, cnt, r_n, h_n, cnt_n, div_c, high_c;
  logic wrap, apply;
  always_comb begin
    div_c = CW'(clamp_div(32'(i_div)));
`ifdef DUTY_CFG_EN
    high_c = CW'(clamp_high(32'(i_high), 32'(div_c)));
`else
    high_c = div_c >> 1;
`endif
    wrap = cnt == r - 1'b1;
    apply = o_pend && (!i_en || wrap);
    r_n = apply ? r_s : r;
    h_n = apply ? h_s : h;
    cnt_n = (!i_en || wrap) ? '0 : cnt + 1'b1;
  end
`ifndef DUTY_CFG_EN
  logic unused_high;
  assign unused_high = ^i_high;
`endif
  // outputs are registered from next-state so they line up with cnt in the same cycle
  always_ff @(posedge i_clk or negedge rst_n)
    if (!rst_n) begin
      r <= CW'(RST_DIV);
      h <= CW'(RST_HIGH);
      r_s <= CW'(RST_DIV);
      h_s <= CW'(RST_HIGH);
      cnt <= '0;
      o_pend <= 1'b0;
      o_clk <= 1'b0;
      o_tick <= 1'b0;
    end else begin
      cnt <= cnt_n;
      r <= r_n;
      h <= h_n;
      o_clk <= i_en && cnt_n >= r_n - h_n;
      o_tick <= i_en && cnt_n == r_n - 1'b1;
      o_pend <= i_we || (o_pend && !apply);
      if (i_we) begin
        r_s <= div_c;
        h_s <= high_c;
      end
    end
endmodule

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: CH-channel runtime-programmable divider; DUTY_CFG_EN enables programmable high time
module prog_clk_divider #(
  parameter int CH = 4,
  parameter int CW = 16
) (
  input  logic             i_clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    i_en,
  prog_clk_divider_if.slave cfg,
  output logic [CH-1:0]    o_clk,
  output logic [CH-1:0]    o_tick,
  output logic [CH-1:0]    o_pend
);
  localparam int CHW = $clog2(CH);
  logic ch_ok;
  logic [CH-1:0] we;
  assign ch_ok = int'(cfg.i_cfg_ch) < CH;
  assign cfg.o_cfg_ready = !ch_ok || !o_pend[cfg.i_cfg_ch];
  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign we[g] = cfg.i_cfg_valid && cfg.o_cfg_ready && cfg.i_cfg_ch == CHW'(g);
    clk_div_chan #(.CW(CW)) u_chan (
      .i_clk(i_clk),
      .rst_n(rst_n),
      .i_en(i_en[g]),
      .i_we(we[g]),
      .i_div(cfg.i_cfg_div),
      .i_high(cfg.i_cfg_high),
      .o_clk(o_clk[g]),
      .o_tick(o_tick[g]),
      .o_pend(o_pend[g])
    );
  end
endmodule

// File: tb/tb_prog_clk_divider.sv
// tb_prog_clk_divider: directed self-checking bench for prog_clk_divider
module tb_prog_clk_divider;
  localparam int CH = 4;
  localparam int CW = 16;
`ifdef DUTY_CFG_EN
  localparam int H8 = 7;
`else
  localparam int H8 = 4;
`endif
  logic i_clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CH-1:0] i_en = '0;
  logic [CH-1:0] o_clk, o_tick, o_pend;
  int checks = 0;
  int errs = 0;
  prog_clk_divider_if #(.CH(CH), .CW(CW)) cfg ();
  prog_clk_divider #(.CH(CH), .CW(CW)) dut (
    .i_clk(i_clk),
    .rst_n(rst_n),
    .i_en(i_en),
    .cfg(cfg),
    .o_clk(o_clk),
    .o_tick(o_tick),
    .o_pend(o_pend)
  );
  always #5 i_clk = ~i_clk;
  task automatic nc(input int n = 1);
    repeat (n) @(negedge i_clk);
  endtask
  task automatic drive(input logic [1:0] ch, input logic [CW-1:0] div, input logic [CW-1:0] high);
    cfg.i_cfg_valid = 1'b1;
    cfg.i_cfg_ch = ch;
    cfg.i_cfg_div = div;
    cfg.i_cfg_high = high;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    i_en = '0;
    cfg.i_cfg_valid = 1'b0;
    nc(1);
    rst_n = 1'b1;
    i_en = '1;
  endtask
  task automatic test_reset;
    logic [CH-1:0] e;
    rst_n = 1'b0;
    nc(2);
    checks++; if (o_clk !== '0) begin errs++; $display("FAIL rst_clk got %h exp 0", o_clk); end
    checks++; if (o_tick !== '0) begin errs++; $display("FAIL rst_tick got %h exp 0", o_tick); end
    checks++; if (o_pend !== '0) begin errs++; $display("FAIL rst_pend got %h exp 0", o_pend); end
    rst_n = 1'b1;
    i_en = '1;
    for (int k = 0; k < 6; k++) begin
      e = (k % 2 == 1) ? '1 : '0;
      checks++; if (o_clk !== e) begin errs++; $display("FAIL def_clk k=%0d got %h exp %h", k, o_clk, e); end
      checks++; if (o_tick !== e) begin errs++; $display("FAIL def_tick k=%0d got %h exp %h", k, o_tick, e); end
      checks++; if (o_pend !== '0) begin errs++; $display("FAIL def_pend k=%0d got %h exp 0", k, o_pend); end
      nc(1);
    end
  endtask
  task automatic test_div5;
    logic e;
    do_reset();
    drive(2'd1, 16'd5, 16'd2);
    checks++; if (cfg.o_cfg_ready !== 1'b1) begin errs++; $display("FAIL d5_ready got %b exp 1", cfg.o_cfg_ready); end
    nc(1);
    cfg.i_cfg_valid = 1'b0;
    checks++; if (o_pend !== 4'b0010) begin errs++; $display("FAIL d5_pend got %h exp 2", o_pend); end
    checks++; if (o_clk[1] !== 1'b1) begin errs++; $display("FAIL d5_oldclk got %b exp 1", o_clk[1]); end
    nc(1);
    for (int k = 0; k < 10; k++) begin
      e = (k % 5) >= 3;
      checks++; if (o_clk[1] !== e) begin errs++; $display("FAIL d5_clk k=%0d got %b exp %b", k, o_clk[1], e); end
      e = (k % 5) == 4;
      checks++; if (o_tick[1] !== e) begin errs++; $display("FAIL d5_tick k=%0d got %b exp %b", k, o_tick[1], e); end
      checks++; if (o_pend[1] !== 1'b0) begin errs++; $display("FAIL d5_pendclr k=%0d got %b exp 0", k, o_pend[1]); end
      nc(1);
    end
  endtask
  task automatic test_apply_boundary;
    logic e;
    do_reset();
    drive(2'd0, 16'd5, 16'd2);
    nc(1);
    cfg.i_cfg_valid = 1'b0;
    nc(2);
    drive(2'd0, 16'd10, 16'd5);
    checks++; if (cfg.o_cfg_ready !== 1'b1) begin errs++; $display("FAIL ab_ready1 got %b exp 1", cfg.o_cfg_ready); end
    nc(1);
    drive(2'd0, 16'd3, 16'd1);
    for (int j = 0; j < 3; j++) begin
      checks++; if (cfg.o_cfg_ready !== 1'b0) begin errs++; $display("FAIL ab_busy j=%0d got %b exp 0", j, cfg.o_cfg_ready); end
      checks++; if (o_pend[0] !== 1'b1) begin errs++; $display("FAIL ab_pend j=%0d got %b exp 1", j, o_pend[0]); end
      e = (j + 2) >= 3;
      checks++; if (o_clk[0] !== e) begin errs++; $display("FAIL ab_oldclk j=%0d got %b exp %b", j, o_clk[0], e); end
      e = (j + 2) == 4;
      checks++; if (o_tick[0] !== e) begin errs++; $display("FAIL ab_oldtick j=%0d got %b exp %b", j, o_tick[0], e); end
      nc(1);
    end
    checks++; if (cfg.o_cfg_ready !== 1'b1) begin errs++; $display("FAIL ab_ready2 got %b exp 1", cfg.o_cfg_ready); end
    cfg.i_cfg_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      e = (k % 10) >= 5;
      checks++; if (o_clk[0] !== e) begin errs++; $display("FAIL ab_clk k=%0d got %b exp %b", k, o_clk[0], e); end
      e = (k % 10) == 9;
      checks++; if (o_tick[0] !== e) begin errs++; $display("FAIL ab_tick k=%0d got %b exp %b", k, o_tick[0], e); end
      checks++; if (o_pend[0] !== 1'b0) begin errs++; $display("FAIL ab_pend2 k=%0d got %b exp 0", k, o_pend[0]); end
      nc(1);
    end
  endtask
  task automatic test_clamp;
    logic [1:0] e2;
    logic e;
    do_reset();
    drive(2'd2, 16'd0, 16'd0);
    nc(1);
    drive(2'd3, 16'd1, 16'd0);
    nc(1);
    cfg.i_cfg_valid = 1'b0;
    for (int k = 2; k < 10; k++) begin
      e2 = (k % 2 == 1) ? 2'b11 : 2'b00;
      checks++; if (o_clk[3:2] !== e2) begin errs++; $display("FAIL cl_clk k=%0d got %b exp %b", k, o_clk[3:2], e2); end
      checks++; if (o_tick[3:2] !== e2) begin errs++; $display("FAIL cl_tick k=%0d got %b exp %b", k, o_tick[3:2], e2); end
      nc(1);
    end
    drive(2'd1, 16'd8, 16'd9);
    nc(1);
    cfg.i_cfg_valid = 1'b0;
    checks++; if (o_pend[1] !== 1'b1) begin errs++; $display("FAIL cl_pend got %b exp 1", o_pend[1]); end
    nc(1);
    for (int k = 0; k < 16; k++) begin
      e = (k % 8) >= (8 - H8);
      checks++; if (o_clk[1] !== e) begin errs++; $display("FAIL cl8_clk k=%0d got %b exp %b", k, o_clk[1], e); end
      e = (k % 8) == 7;
      checks++; if (o_tick[1] !== e) begin errs++; $display("FAIL cl8_tick k=%0d got %b exp %b", k, o_tick[1], e); end
      nc(1);
    end
  endtask
  task automatic test_enable;
    logic e;
    do_reset();
    drive(2'd2, 16'd4, 16'd2);
    nc(1);
    cfg.i_cfg_valid = 1'b0;
    nc(3);
    checks++; if (o_clk[2] !== 1'b1) begin errs++; $display("FAIL en_pre got %b exp 1", o_clk[2]); end
    i_en[2] = 1'b0;
    nc(1);
    drive(2'd2, 16'd3, 16'd1);
    checks++; if (cfg.o_cfg_ready !== 1'b1) begin errs++; $display("FAIL en_ready got %b exp 1", cfg.o_cfg_ready); end
    checks++; if (o_clk[2] !== 1'b0) begin errs++; $display("FAIL en_off0 got %b exp 0", o_clk[2]); end
    nc(1);
    cfg.i_cfg_valid = 1'b0;
    checks++; if (o_pend[2] !== 1'b1) begin errs++; $display("FAIL en_pend1 got %b exp 1", o_pend[2]); end
    checks++; if (o_clk[2] !== 1'b0) begin errs++; $display("FAIL en_off1 got %b exp 0", o_clk[2]); end
    nc(1);
    checks++; if (o_pend[2] !== 1'b0) begin errs++; $display("FAIL en_pend2 got %b exp 0", o_pend[2]); end
    checks++; if (o_tick[2] !== 1'b0) begin errs++; $display("FAIL en_offtick got %b exp 0", o_tick[2]); end
    nc(1);
    checks++; if (o_clk[2] !== 1'b0) begin errs++; $display("FAIL en_off3 got %b exp 0", o_clk[2]); end
    nc(1);
    i_en[2] = 1'b1;
    for (int m = 0; m < 9; m++) begin
      e = (m % 3) >= 2;
      checks++; if (o_clk[2] !== e) begin errs++; $display("FAIL en_clk m=%0d got %b exp %b", m, o_clk[2], e); end
      checks++; if (o_tick[2] !== e) begin errs++; $display("FAIL en_tick m=%0d got %b exp %b", m, o_tick[2], e); end
      e = (m % 2) == 0;
      checks++; if (o_clk[0] !== e) begin errs++; $display("FAIL en_ch0 m=%0d got %b exp %b", m, o_clk[0], e); end
      nc(1);
    end
  endtask
  task automatic test_reset_pend;
    logic e;
    do_reset();
    drive(2'd3, 16'd6, 16'd3);
    nc(1);
    cfg.i_cfg_valid = 1'b0;
    checks++; if (o_pend !== 4'b1000) begin errs++; $display("FAIL rp_pend got %h exp 8", o_pend); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_pend !== '0) begin errs++; $display("FAIL rp_apend got %h exp 0", o_pend); end
    checks++; if (o_clk !== '0) begin errs++; $display("FAIL rp_aclk got %h exp 0", o_clk); end
    checks++; if (o_tick !== '0) begin errs++; $display("FAIL rp_atick got %h exp 0", o_tick); end
    nc(1);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e = (k % 2) == 1;
      checks++; if (o_clk[3] !== e) begin errs++; $display("FAIL rp_clk k=%0d got %b exp %b", k, o_clk[3], e); end
      checks++; if (o_pend !== '0) begin errs++; $display("FAIL rp_pend2 k=%0d got %h exp 0", k, o_pend); end
      nc(1);
    end
  endtask
  initial begin
    cfg.i_cfg_valid = 1'b0;
    cfg.i_cfg_ch = '0;
    cfg.i_cfg_div = '0;
    cfg.i_cfg_high = '0;
    nc(1);
    test_reset();
    test_div5();
    test_apply_boundary();
    test_clamp();
    test_enable();
    test_reset_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
